// File: rtl/mci_dmi_sram_bridge.sv
// mci_dmi_sram_bridge
// Turns DMI uncore accesses to the MCU SRAM window (0x58 ADDR, 0x59 DATA)
// into single-word req/ack SRAM transactions. The address auto-increments
// after every DATA access and the next word is prefetched into buf_q, so a
// DATA read always answers in one cycle from the buffer.
module mci_dmi_sram_bridge #(
   parameter int unsigned ADDR_W  = 21,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dbg_unlocked,
   input  logic              dmi_uncore_en,
   input  logic              dmi_uncore_wr_en,
   input  logic [6:0]        dmi_uncore_addr,
   input  logic [31:0]       dmi_uncore_wdata,
   output logic [31:0]       dmi_uncore_rdata,
   output logic              dmi_hit,
   output logic              sram_req,
   output logic              sram_we,
   output logic [ADDR_W-3:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata,
   input  logic              sram_ack,
   output logic              busy
);

   localparam int unsigned CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [6:0]  REG_ADDR = 7'h58;
   localparam logic [6:0]  REG_DATA = 7'h59;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       buf_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              req_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              hit_q;

   logic              hit_addr;
   logic              hit_data;
   logic              addr_wr;
   logic              addr_rd;
   logic              data_wr;
   logic              data_rd;
   logic              any_mod;
   logic              timeout;
   logic [ADDR_W-1:0] addr_inc;
   logic [31:0]       rdback;
   logic              unused_wdata_bits;

   assign busy             = (state_q != S_IDLE);
   assign sram_req         = req_q;
   assign sram_we          = we_q;
   assign sram_addr        = addr_q[ADDR_W-1:2];
   assign sram_wdata       = wdata_q;
   assign dmi_uncore_rdata = rdata_q;
   assign dmi_hit          = hit_q;
   // Only wdata[ADDR_W-1:2] feeds the address; the rest is don't-care there.
   assign unused_wdata_bits = ^dmi_uncore_wdata;

   // Decode the DMI strobe and build the ADDR-register readback word.
   always_comb begin
      hit_addr = dmi_uncore_en && dbg_unlocked && (dmi_uncore_addr == REG_ADDR);
      hit_data = dmi_uncore_en && dbg_unlocked && (dmi_uncore_addr == REG_DATA);
      addr_wr  = hit_addr && dmi_uncore_wr_en;
      addr_rd  = hit_addr && !dmi_uncore_wr_en;
      data_wr  = hit_data && dmi_uncore_wr_en;
      data_rd  = hit_data && !dmi_uncore_wr_en;
      any_mod  = addr_wr || data_wr || data_rd;
      timeout  = (cnt_q == CNT_W'(TIMEOUT - 1));
      addr_inc = addr_q + ADDR_W'(4);
      rdback   = '0;
      rdback[ADDR_W-1:2] = addr_q[ADDR_W-1:2];
      rdback[1] = err_q;
      rdback[0] = busy;
   end

   // Bridge FSM: DMI response, SRAM request/handshake, timeout and error tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         if (dmi_uncore_en) begin
            hit_q <= hit_addr || hit_data;
            if (addr_rd)      rdata_q <= rdback;
            else if (data_rd) rdata_q <= buf_q;
            else              rdata_q <= '0;
         end

         // Any modifying access outside IDLE is dropped and flagged.
         if (state_q != S_IDLE && any_mod) err_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (addr_wr) begin
                  addr_q  <= {dmi_uncore_wdata[ADDR_W-1:2], 2'b00};
                  err_q   <= 1'b0;
                  state_q <= S_READ;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  cnt_q   <= '0;
               end else if (data_wr) begin
                  wdata_q <= dmi_uncore_wdata;
                  state_q <= S_WRITE;
                  req_q   <= 1'b1;
                  we_q    <= 1'b1;
                  cnt_q   <= '0;
               end else if (data_rd) begin
                  addr_q  <= addr_inc;
                  state_q <= S_READ;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            S_WRITE: begin
               if (sram_ack) begin
                  // req stays high: the prefetch of the next word starts at once.
                  addr_q  <= addr_inc;
                  state_q <= S_READ;
                  we_q    <= 1'b0;
                  cnt_q   <= '0;
               end else if (timeout) begin
                  state_q <= S_IDLE;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_READ: begin
               if (sram_ack) begin
                  buf_q   <= sram_rdata;
                  state_q <= S_IDLE;
                  req_q   <= 1'b0;
               end else if (timeout) begin
                  buf_q   <= '0;
                  state_q <= S_IDLE;
                  req_q   <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mci_dmi_sram_bridge.sv
// Testbench for mci_dmi_sram_bridge: table-driven DMI vectors plus
// hand-written multi-cycle sequences; SRAM transactions are checked
// against a scoreboard queue filled when the DMI stimulus is issued.
module tb_mci_dmi_sram_bridge;

   localparam int unsigned ADDR_W  = 21;
   localparam int unsigned TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dbg_unlocked = 1'b1;
   logic        dmi_uncore_en = 1'b0;
   logic        dmi_uncore_wr_en = 1'b0;
   logic [6:0]  dmi_uncore_addr = '0;
   logic [31:0] dmi_uncore_wdata = '0;
   logic [31:0] dmi_uncore_rdata;
   logic        dmi_hit;
   logic        sram_req;
   logic        sram_we;
   logic [18:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = '0;
   logic        sram_ack = 1'b0;
   logic        busy;

   mci_dmi_sram_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .rst              (rst),
      .dbg_unlocked     (dbg_unlocked),
      .dmi_uncore_en    (dmi_uncore_en),
      .dmi_uncore_wr_en (dmi_uncore_wr_en),
      .dmi_uncore_addr  (dmi_uncore_addr),
      .dmi_uncore_wdata (dmi_uncore_wdata),
      .dmi_uncore_rdata (dmi_uncore_rdata),
      .dmi_hit          (dmi_hit),
      .sram_req         (sram_req),
      .sram_we          (sram_we),
      .sram_addr        (sram_addr),
      .sram_wdata       (sram_wdata),
      .sram_rdata       (sram_rdata),
      .sram_ack         (sram_ack),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [18:0] a;
      logic [31:0] d;
   } sram_t;

   typedef struct {
      logic        wr;
      logic [6:0]  a;
      logic [31:0] wd;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_hit;
      int unsigned npush;
      sram_t       p0;
      sram_t       p1;
   } vec_t;

   int    checks = 0;
   int    fails  = 0;
   sram_t exp_q[$];
   vec_t  vecs[$];

   logic  ack_en    = 1'b1;
   logic  force_ack = 1'b0;
   int    ack_delay = 0;
   int    wait_cnt  = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", n, act, exp);
      end
   endtask

   function automatic logic [31:0] sram_word(input logic [18:0] a);
      if (a == 19'h400) return 32'hCAFE_0001;
      return {13'h1ABC, a};
   endfunction

   function automatic sram_t tx(input logic we, input logic [18:0] a, input logic [31:0] d);
      sram_t t;
      t.we = we;
      t.a  = a;
      t.d  = d;
      return t;
   endfunction

   function automatic vec_t mkv(input logic wr, input logic [6:0] a, input logic [31:0] wd,
                                input logic chk_rd, input logic [31:0] er, input logic eh,
                                input int unsigned np, input sram_t p0, input sram_t p1);
      vec_t v;
      v.wr = wr; v.a = a; v.wd = wd; v.chk_rd = chk_rd; v.exp_rd = er;
      v.exp_hit = eh; v.npush = np; v.p0 = p0; v.p1 = p1;
      return v;
   endfunction

   // SRAM responder: acks after ack_delay cycles of req, checks against scoreboard.
   always @(negedge clk) begin
      sram_t e;
      sram_ack = force_ack;
      if (sram_req && !rst) begin
         if (ack_en && wait_cnt >= ack_delay) begin
            sram_ack   = 1'b1;
            sram_rdata = sram_word(sram_addr);
            wait_cnt   = 0;
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL sram_unexpected actual_addr=0x%05h actual_we=%0d required=none",
                        sram_addr, sram_we);
            end else begin
               e = exp_q.pop_front();
               chk("sram_we", {31'd0, sram_we}, {31'd0, e.we});
               chk("sram_addr", {13'd0, sram_addr}, {13'd0, e.a});
               if (e.we) chk("sram_wdata", sram_wdata, e.d);
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   task automatic dmi(input logic wr, input logic [6:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic hit);
      @(negedge clk);
      dmi_uncore_en    = 1'b1;
      dmi_uncore_wr_en = wr;
      dmi_uncore_addr  = a;
      dmi_uncore_wdata = wd;
      @(posedge clk);
      #1;
      dmi_uncore_en    = 1'b0;
      dmi_uncore_wr_en = 1'b0;
      rd  = dmi_uncore_rdata;
      hit = dmi_hit;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         @(posedge clk);
         #1;
      end
      chk("wait_idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        hit;
      int          n;
      sram_t       none;
      none = '0;

      // Vector table: each access is issued from IDLE with a zero-wait SRAM.
      vecs.push_back(mkv(0, 7'h58, 0,             1, 32'h0,               1, 0, none, none));
      vecs.push_back(mkv(1, 7'h58, 32'h100,       0, 0,                   1, 1, tx(0, 19'h40, 0), none));
      vecs.push_back(mkv(1, 7'h59, 32'hA5A5_A5A5, 0, 0,                   1, 2, tx(1, 19'h40, 32'hA5A5_A5A5), tx(0, 19'h41, 0)));
      vecs.push_back(mkv(1, 7'h59, 32'h5A5A_5A5A, 0, 0,                   1, 2, tx(1, 19'h41, 32'h5A5A_5A5A), tx(0, 19'h42, 0)));
      vecs.push_back(mkv(0, 7'h58, 0,             1, 32'h108,             1, 0, none, none));
      vecs.push_back(mkv(0, 7'h59, 0,             1, sram_word(19'h42),   1, 1, tx(0, 19'h43, 0), none));
      vecs.push_back(mkv(0, 7'h58, 0,             1, 32'h10C,             1, 0, none, none));
      vecs.push_back(mkv(1, 7'h10, 32'h1234,      0, 0,                   0, 0, none, none));
      vecs.push_back(mkv(0, 7'h10, 0,             1, 32'h0,               0, 0, none, none));
      vecs.push_back(mkv(1, 7'h58, 32'h1F_FFFF,   0, 0,                   1, 1, tx(0, 19'h7FFFF, 0), none));
      vecs.push_back(mkv(0, 7'h59, 0,             1, sram_word(19'h7FFFF),1, 1, tx(0, 19'h0, 0), none));
      vecs.push_back(mkv(0, 7'h58, 0,             1, 32'h0,               1, 0, none, none));
      vecs.push_back(mkv(1, 7'h58, 32'h30_1003,   0, 0,                   1, 1, tx(0, 19'h40400, 0), none));
      vecs.push_back(mkv(0, 7'h58, 0,             1, 32'h10_1000,         1, 0, none, none));
      vecs.push_back(mkv(0, 7'h5A, 0,             1, 32'h0,               0, 0, none, none));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req",   {31'd0, sram_req}, 32'd0);
      chk("rst_we",    {31'd0, sram_we}, 32'd0);
      chk("rst_addr",  {13'd0, sram_addr}, 32'd0);
      chk("rst_wdata", sram_wdata, 32'd0);
      chk("rst_rdata", dmi_uncore_rdata, 32'd0);
      chk("rst_hit",   {31'd0, dmi_hit}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].npush > 0) exp_q.push_back(vecs[i].p0);
         if (vecs[i].npush > 1) exp_q.push_back(vecs[i].p1);
         dmi(vecs[i].wr, vecs[i].a, vecs[i].wd, rd, hit);
         if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
         wait_idle();
      end

      // Slow SRAM prefetch, then DATA read returns the prefetched word.
      ack_delay = 3;
      exp_q.push_back(tx(0, 19'h400, 0));
      dmi(1, 7'h58, 32'h1000, rd, hit);
      chk("slow_req",  {31'd0, sram_req}, 32'd1);
      chk("slow_addr", {13'd0, sram_addr}, 32'h400);
      chk("slow_we",   {31'd0, sram_we}, 32'd0);
      dmi(0, 7'h58, 0, rd, hit);
      chk("slow_busy_rdback", rd, 32'h1001);
      wait_idle();
      exp_q.push_back(tx(0, 19'h401, 0));
      dmi(0, 7'h59, 0, rd, hit);
      chk("slow_data", rd, 32'hCAFE_0001);
      wait_idle();
      ack_delay = 0;

      // Zero-wait prefetch chain after a DATA write.
      exp_q.push_back(tx(1, 19'h401, 32'h0BAD_F00D));
      exp_q.push_back(tx(0, 19'h402, 0));
      dmi(1, 7'h59, 32'h0BAD_F00D, rd, hit);
      chk("chain1_req", {31'd0, sram_req}, 32'd1);
      chk("chain1_we",  {31'd0, sram_we}, 32'd1);
      @(posedge clk); #1;
      chk("chain2_req", {31'd0, sram_req}, 32'd1);
      chk("chain2_we",  {31'd0, sram_we}, 32'd0);
      @(posedge clk); #1;
      chk("chain3_busy", {31'd0, busy}, 32'd0);
      chk("chain3_req",  {31'd0, sram_req}, 32'd0);

      // Read timeout.
      ack_en = 1'b0;
      dmi(1, 7'h58, 32'h200, rd, hit);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         if (!sram_req) break;
         n++;
         @(posedge clk); #1;
      end
      chk("to_req_cycles", n, TIMEOUT);
      dmi(0, 7'h58, 0, rd, hit);
      chk("to_rdback", rd, 32'h202);
      ack_en = 1'b1;
      exp_q.push_back(tx(0, 19'h81, 0));
      dmi(0, 7'h59, 0, rd, hit);
      chk("to_buf_zero", rd, 32'h0);
      wait_idle();
      exp_q.push_back(tx(0, 19'hC0, 0));
      dmi(1, 7'h58, 32'h300, rd, hit);
      wait_idle();
      dmi(0, 7'h58, 0, rd, hit);
      chk("to_err_cleared", rd, 32'h300);

      // Overrun while stalled, then locked access.
      ack_en = 1'b0;
      dmi(1, 7'h58, 32'h400, rd, hit);
      dmi(1, 7'h59, 32'hDEAD_BEEF, rd, hit);
      chk("ovr_hit", {31'd0, hit}, 32'd1);
      dmi(0, 7'h58, 0, rd, hit);
      chk("ovr_rdback_busy", rd, 32'h403);
      exp_q.push_back(tx(0, 19'h100, 0));
      ack_en = 1'b1;
      wait_idle();
      dmi(0, 7'h58, 0, rd, hit);
      chk("ovr_rdback_idle", rd, 32'h402);
      dbg_unlocked = 1'b0;
      dmi(1, 7'h58, 32'h800, rd, hit);
      chk("lock_wr_hit",  {31'd0, hit}, 32'd0);
      chk("lock_wr_busy", {31'd0, busy}, 32'd0);
      dmi(0, 7'h58, 0, rd, hit);
      chk("lock_rd_rdata", rd, 32'h0);
      chk("lock_rd_hit",   {31'd0, hit}, 32'd0);
      dbg_unlocked = 1'b1;
      dmi(0, 7'h58, 0, rd, hit);
      chk("lock_addr_kept", rd, 32'h402);

      // Reset during a stalled write; a late ack must be ignored.
      exp_q.push_back(tx(0, 19'h140, 0));
      dmi(1, 7'h58, 32'h500, rd, hit);
      wait_idle();
      ack_en = 1'b0;
      dmi(1, 7'h59, 32'h1234_5678, rd, hit);
      chk("rw_req",   {31'd0, sram_req}, 32'd1);
      chk("rw_we",    {31'd0, sram_we}, 32'd1);
      chk("rw_wdata", sram_wdata, 32'h1234_5678);
      chk("rw_addr",  {13'd0, sram_addr}, 32'h140);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rw_rst_req",  {31'd0, sram_req}, 32'd0);
      chk("rw_rst_busy", {31'd0, busy}, 32'd0);
      chk("rw_rst_addr", {13'd0, sram_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      force_ack = 1'b1;
      @(posedge clk); #1;
      force_ack = 1'b0;
      @(posedge clk); #1;
      chk("late_ack_busy", {31'd0, busy}, 32'd0);
      chk("late_ack_req",  {31'd0, sram_req}, 32'd0);
      dmi(0, 7'h58, 0, rd, hit);
      chk("late_ack_rdback", rd, 32'h0);

      repeat (3) @(posedge clk);
      chk("sb_leftover", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
